serial_regfile_slave: RTL and testbench

SERIAL_REGFILE_SLAVE -- requirements
Module: serial_regfile_slave

---
 rtl/serial_regfile_slave_if.sv | 21 ++
 rtl/serial_regfile_slave.sv | 201 ++++++++++++++++++++
 tb/tb_serial_regfile_slave.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_regfile_slave_if.sv
// Serial frame port of serial_regfile_slave: host drives strobe/din,
// slave returns serial read data and status.
interface serial_regfile_slave_if;
  logic strobe;
  logic din;
  logic dout;
  logic dout_valid;
  logic busy;
  logic done;
  logic err;

  modport master (
    output strobe, din,
    input  dout, dout_valid, busy, done, err
  );

  modport slave (
    input  strobe, din,
    output dout, dout_valid, busy, done, err
  );
endinterface

// File: rtl/serial_regfile_slave.sv
// Serial-framed register file slave: writable registers plus synchronised read-only inputs.
// Define SERREG_PARITY_EN to add an even-parity bit to write frames.
module serial_regfile_slave #(
  parameter int ADDR_WIDTH = 5,
  parameter int REG_WIDTH  = 8,
  parameter int NUM_WR     = 9,
  parameter int NUM_RD     = 8,
  parameter logic [NUM_WR*REG_WIDTH-1:0] WR_RESET = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_regfile_slave_if.slave         bus,
  input  logic [NUM_RD*REG_WIDTH-1:0]   rd_bus,
  output logic [NUM_WR*REG_WIDTH-1:0]   wr_bus
);

  localparam int MAX_W = (ADDR_WIDTH > REG_WIDTH) ? ADDR_WIDTH : REG_WIDTH;
  localparam int CNT_W = $clog2(MAX_W) + 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(REG_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, COMMIT, LOOKUP, SEND
`ifdef SERREG_PARITY_EN
    , PARITY
`endif
  } state_e;

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           op_q, op_d;
  logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
  logic [REG_WIDTH-1:0]           data_q, data_d;
  logic [REG_WIDTH-1:0]           shift_q, shift_d;
  logic                           err_q, err_d;
  logic [NUM_WR*REG_WIDTH-1:0]    wr_q, wr_d;
  logic [NUM_RD*REG_WIDTH-1:0]    sync_meta_q, sync_meta_d;
  logic [NUM_RD*REG_WIDTH-1:0]    sync_q, sync_d;
`ifdef SERREG_PARITY_EN
  logic                           par_err_q, par_err_d;
`endif

  logic [REG_WIDTH-1:0]           rd_sel;
  logic                           rd_oob;
  logic                           wr_ok;
  logic                           dout, dout_valid, done;

  // Read mux: writable registers, then synchronised read-only slices, else zero.
  always_comb begin
    rd_sel = '0;
    rd_oob = 1'b1;
    for (int k = 0; k < NUM_WR; k++) begin
      if (int'(addr_q) == k) begin
        rd_sel = wr_q[k*REG_WIDTH +: REG_WIDTH];
        rd_oob = 1'b0;
      end
    end
    for (int k = 0; k < NUM_RD; k++) begin
      if (int'(addr_q) == NUM_WR + k) begin
        rd_sel = sync_q[k*REG_WIDTH +: REG_WIDTH];
        rd_oob = 1'b0;
      end
    end
  end

`ifdef SERREG_PARITY_EN
  assign wr_ok = (int'(addr_q) < NUM_WR) && !par_err_q;
`else
  assign wr_ok = (int'(addr_q) < NUM_WR);
`endif

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    shift_d     = shift_q;
    err_d       = err_q;
    wr_d        = wr_q;
    sync_meta_d = rd_bus;
    sync_d      = sync_meta_q;
`ifdef SERREG_PARITY_EN
    par_err_d   = par_err_q;
`endif
    dout        = 1'b0;
    dout_valid  = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.strobe) begin
          state_d = CMD;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      CMD: begin
        op_d    = bus.din;
        cnt_d   = '0;
        state_d = ADDR;
      end
      ADDR: begin
        addr_d = {bus.din, addr_q[ADDR_WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == ADDR_LAST) begin
          cnt_d   = '0;
          state_d = op_q ? WDATA : LOOKUP;
        end
      end
      WDATA: begin
        data_d = {bus.din, data_q[REG_WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == DATA_LAST) begin
          cnt_d = '0;
`ifdef SERREG_PARITY_EN
          state_d = PARITY;
`else
          state_d = COMMIT;
`endif
        end
      end
`ifdef SERREG_PARITY_EN
      PARITY: begin
        // Even parity over op, address, data and the parity bit itself.
        par_err_d = bus.din ^ op_q ^ (^addr_q) ^ (^data_q);
        state_d   = COMMIT;
      end
`endif
      COMMIT: begin
        done = 1'b1;
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_ok && int'(addr_q) == k) wr_d[k*REG_WIDTH +: REG_WIDTH] = data_q;
        end
        if (!wr_ok) err_d = 1'b1;
        state_d = IDLE;
      end
      LOOKUP: begin
        shift_d = rd_sel;
        if (rd_oob) err_d = 1'b1;
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        dout       = shift_q[0];
        dout_valid = 1'b1;
        shift_d    = shift_q >> 1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == DATA_LAST) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      shift_q     <= '0;
      err_q       <= 1'b0;
      // NOTE: the register file is flops, not RAM, so it takes its reset image directly.
      wr_q        <= WR_RESET;
      sync_meta_q <= '0;
      sync_q      <= '0;
`ifdef SERREG_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      shift_q     <= shift_d;
      err_q       <= err_d;
      wr_q        <= wr_d;
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
`ifdef SERREG_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.done       = done;
  assign bus.busy       = (state_q != IDLE);
  assign bus.err        = err_q;
  assign wr_bus         = wr_q;

endmodule

// File: tb/tb_serial_regfile_slave.sv
// Self-checking bench for serial_regfile_slave: directed frames plus randomized
// frames against a register-array reference model.
module tb_serial_regfile_slave;
  localparam int AW  = 5;
  localparam int RW  = 8;
  localparam int NWR = 9;
  localparam int NRD = 8;
`ifdef SERREG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [NRD*RW-1:0]  rd_bus;
  logic [NWR*RW-1:0]  wr_bus;

  serial_regfile_slave_if bus();

  serial_regfile_slave dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .rd_bus (rd_bus),
    .wr_bus (wr_bus)
  );

  always #5 clk = ~clk;

  logic [RW-1:0] ref_wr [NWR];
  bit            ref_err;
  int unsigned   n_vec = 0;
  int unsigned   n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NWR*RW-1:0] model_bus();
    logic [NWR*RW-1:0] v;
    for (int k = 0; k < NWR; k++) v[k*RW +: RW] = ref_wr[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NWR; k++) ref_wr[k] = '0;
    ref_err = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input bit op, input logic [AW-1:0] av, input bit noisy);
    bus.strobe = 1'b1;
    bus.din    = 1'b0;
    tick();
    bus.strobe = 1'b0;
    ref_err    = 1'b0;
    check("cmd_busy", bus.busy, 1);
    check("cmd_err_cleared", bus.err, ref_err);
    bus.din = op;
    tick();
    for (int i = 0; i < AW; i++) begin
      bus.din    = av[i];
      bus.strobe = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
  endtask

  task automatic do_write(input int a, input logic [RW-1:0] d, input bit bad_par, input bit noisy);
    logic [AW-1:0] av;
    bit eff_bad;
    av      = AW'(a);
    eff_bad = PAR_EN && bad_par;
    start_frame(1'b1, av, noisy);
    for (int i = 0; i < RW; i++) begin
      bus.din    = d[i];
      bus.strobe = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    if (PAR_EN) begin
      bus.din = (^{1'b1, av, d}) ^ bad_par;
      tick();
    end
    check("commit_done", bus.done, 1);
    check("commit_dout_valid", bus.dout_valid, 0);
    bus.strobe = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    bus.strobe = 1'b0;
    if (a < NWR && !eff_bad) ref_wr[a] = d;
    else ref_err = 1'b1;
    check("wr_bus", wr_bus, model_bus());
    check("wr_err", bus.err, ref_err);
    check("wr_idle_busy", bus.busy, 0);
    check("wr_idle_done", bus.done, 0);
  endtask

  task automatic do_read(input int a, input bit noisy);
    logic [RW-1:0] exp;
    bit oob;
    oob = 1'b0;
    if (a < NWR) exp = ref_wr[a];
    else if (a < NWR + NRD) exp = rd_bus[(a-NWR)*RW +: RW];
    else begin
      exp = '0;
      oob = 1'b1;
    end
    start_frame(1'b0, AW'(a), noisy);
    check("lookup_dout_valid", bus.dout_valid, 0);
    check("lookup_busy", bus.busy, 1);
    tick();
    if (oob) ref_err = 1'b1;
    for (int i = 0; i < RW; i++) begin
      check("rd_dout", bus.dout, exp[i]);
      check("rd_dout_valid", bus.dout_valid, 1);
      check("rd_done", bus.done, (i == RW-1));
      check("rd_err", bus.err, ref_err);
      bus.strobe = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    bus.strobe = 1'b0;
    check("rd_idle_dout_valid", bus.dout_valid, 0);
    check("rd_idle_dout", bus.dout, 0);
    check("rd_idle_busy", bus.busy, 0);
    check("rd_idle_err", bus.err, ref_err);
  endtask

  task automatic abort_write(input int a, input int nbits);
    start_frame(1'b1, AW'(a), 1'b0);
    for (int i = 0; i < nbits; i++) begin
      bus.din = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b1;
    bus.din = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("abort_busy", bus.busy, 0);
    check("abort_wr_bus", wr_bus, model_bus());
    check("abort_err", bus.err, 0);
    tick();
    check("abort_idle_busy", bus.busy, 0);
    check("abort_wr_bus_after", wr_bus, model_bus());
  endtask

  task automatic set_rd(input logic [NRD*RW-1:0] v);
    rd_bus = v;
    repeat (4) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    bus.strobe = 1'b1;
    bus.din    = 1'b0;
    rd_bus     = '0;
    model_reset();
    repeat (3) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_wr_bus", wr_bus, model_bus());
    rst        = 1'b0;
    bus.strobe = 1'b0;
    tick();
    check("post_rst_idle", bus.busy, 0);

    do_write(3, 8'hA5, 1'b0, 1'b0);
    check("wr3_slice", wr_bus[31:24], 8'hA5);
    do_read(3, 1'b0);

    set_rd({{(NRD-1)*RW{1'b0}}, 8'h3C});
    do_read(9, 1'b0);
    do_read(20, 1'b0);
    repeat (3) tick();
    check("err_sticky", bus.err, 1);

    do_write(20, 8'hFF, 1'b0, 1'b0);
    abort_write(2, 4);
    check("abort_slot2", wr_bus[23:16], 8'h00);

    if (PAR_EN) begin
      do_write(1, 8'h01, 1'b1, 1'b0);
      check("par_bad_slot1", wr_bus[15:8], 8'h00);
      do_write(1, 8'h01, 1'b0, 1'b0);
      check("par_good_slot1", wr_bus[15:8], 8'h01);
    end

    for (int n = 0; n < 80; n++) begin
      int sel;
      int a;
      sel = int'($urandom_range(0, 9));
      a   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                        : int'($urandom_range(0, NWR + NRD - 1));
      if (sel == 0) begin
        set_rd({$urandom, $urandom});
      end else if (sel == 1) begin
        abort_write(int'($urandom_range(0, NWR - 1)), int'($urandom_range(0, RW - 1)));
      end else if (sel < 6) begin
        do_write(a, RW'($urandom), ($urandom_range(0, 4) == 0), 1'b1);
      end else begin
        do_read(a, 1'b1);
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
